// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the command record carried from issue to retire.
package alu_pkg;

   localparam logic [2:0] OP_ADD     = 3'b000;
   localparam logic [2:0] OP_SUBAB   = 3'b001;
   localparam logic [2:0] OP_SUBBA   = 3'b010;
   localparam logic [2:0] OP_OR      = 3'b011;
   localparam logic [2:0] OP_AND     = 3'b100;
   localparam logic [2:0] OP_XOR     = 3'b101;
   localparam logic [2:0] OP_XNOR    = 3'b110;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   // Tag field is sized for the widest tag any instance may use; narrower tags zero-extend.
   localparam int unsigned TAG_W_MAX = 16;

   typedef struct packed {
      logic [63:0]          a;
      logic [63:0]          b;
      logic [2:0]           oper;
      logic [TAG_W_MAX-1:0] tag;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO of ALU commands; head is read combinationally.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  alu_cmd_t                     wr_data,
   output alu_cmd_t                     head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   alu_cmd_t      mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/alu_64bit_issue_stage.sv
// Issue/retire stage: buffers ALU commands, drives the external ALU from the FIFO head,
// and captures each result into a single registered output slot with backpressure.
module alu_64bit_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [63:0]                  in_a,
   input  logic [63:0]                  in_b,
   input  logic [2:0]                   in_oper,
   input  logic [TAG_W-1:0]             in_tag,
   output logic [63:0]                  alu_a,
   output logic [63:0]                  alu_b,
   output logic [2:0]                   alu_oper,
   input  logic [63:0]                  alu_sum,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [63:0]                  out_sum,
   output logic [TAG_W-1:0]             out_tag,
   output logic                         out_zero,
   output logic                         out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   alu_cmd_t wr_cmd;
   alu_cmd_t head;
   logic     full;
   logic     empty;
   logic     push;
   logic     load;
   logic     unused_tag_hi;

   assign wr_cmd = '{a: in_a, b: in_b, oper: in_oper, tag: TAG_W_MAX'(in_tag)};

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (load),
      .wr_data (wr_cmd),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (occupancy)
   );

   assign in_ready = ~full;
   assign push     = in_valid & in_ready;
   assign load     = ~empty & (~out_valid | out_ready);

   // An empty FIFO presents the illegal opcode so the ALU returns zero.
   assign alu_a    = empty ? '0 : head.a;
   assign alu_b    = empty ? '0 : head.b;
   assign alu_oper = empty ? OP_ILLEGAL : head.oper;

   assign unused_tag_hi = &{1'b0, head.tag};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_sum     <= '0;
         out_tag     <= '0;
         out_zero    <= 1'b0;
         out_illegal <= 1'b0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_sum     <= alu_sum;
         out_tag     <= head.tag[TAG_W-1:0];
         out_zero    <= (alu_sum == '0);
         out_illegal <= (head.oper == OP_ILLEGAL);
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_64bit_issue_stage.sv
// Scoreboard bench for alu_64bit_issue_stage with a behavioural ALU attached to the alu_* ports.
module tb_alu_64bit_issue_stage;

   typedef struct {
      logic [63:0] sum;
      logic [3:0]  tag;
      logic        zero;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_a = '0;
   logic [63:0] in_b = '0;
   logic [2:0]  in_oper = '0;
   logic [3:0]  in_tag = '0;
   logic [63:0] alu_a, alu_b, alu_sum;
   logic [2:0]  alu_oper;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_sum;
   logic [3:0]  out_tag;
   logic        out_zero, out_illegal;
   logic [2:0]  occupancy;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned n_popped = 0;
   int unsigned cyc = 0;
   exp_t        exp_q[$];

   alu_64bit_issue_stage #(.DEPTH(4), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_oper(in_oper), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_sum(alu_sum),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] op);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return b - a;
         3'd3: return a | b;
         3'd4: return a & b;
         3'd5: return a ^ b;
         3'd6: return ~(a ^ b);
         default: return 64'd0;
      endcase
   endfunction

   // The ALU this stage is wired to in the real design.
   assign alu_sum = ref_alu(alu_a, alu_b, alu_oper);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor/scoreboard: handshakes are sampled on the falling edge, ahead of the rising edge.
   logic        hold_prev = 1'b0;
   logic [63:0] h_sum;
   logic [3:0]  h_tag;
   logic        h_zero, h_ill;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", out_sum, h_sum);
            chk("hold_tag", 64'(out_tag), 64'(h_tag));
            chk("hold_flags", 64'({out_zero, out_illegal}), 64'({h_zero, h_ill}));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output: got tag %0h expected none", out_tag);
            end else begin
               e = exp_q.pop_front();
               chk("sb_sum", out_sum, e.sum);
               chk("sb_tag", 64'(out_tag), 64'(e.tag));
               chk("sb_zero", 64'(out_zero), 64'(e.zero));
               chk("sb_illegal", 64'(out_illegal), 64'(e.illegal));
               n_popped++;
            end
         end
         if (in_valid && in_ready) begin
            e.sum = ref_alu(in_a, in_b, in_oper);
            e.tag = in_tag;
            e.zero = (e.sum == 64'd0);
            e.illegal = (in_oper == 3'b111);
            exp_q.push_back(e);
         end
         hold_prev = out_valid && !out_ready;
         h_sum = out_sum; h_tag = out_tag; h_zero = out_zero; h_ill = out_illegal;
      end
   end

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
      int unsigned w = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_oper = op; in_tag = tag;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) chk("send_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned w = 0;
      while ((exp_q.size() != 0 || out_valid) && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] all1;
      int unsigned c0, p0;
      all1 = '1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_alu_oper", 64'(alu_oper), 64'd7);
      chk("rst_out_sum", out_sum, 64'd0);
      chk("rst_out_fields", 64'({out_tag, out_zero, out_illegal}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Two-edge latency on the first operation.
      send(64'd5, 64'd3, 3'b001, 4'd1);
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_sum", out_sum, 64'd2);
      chk("lat_tag", 64'(out_tag), 64'd1);
      chk("lat_zero", 64'(out_zero), 64'd0);
      send(64'd5, 64'd3, 3'b010, 4'd2);
      send(all1, 64'd1, 3'b000, 4'd3);
      drain();

      // Backpressure: one in the slot plus a full FIFO.
      out_ready = 1'b0;
      for (int unsigned i = 0; i < 5; i++)
         send({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)), 4'(i));
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_occupancy", 64'(occupancy), 64'd4);
      chk("full_head_tag", 64'(out_tag), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      // Push attempt while full, concurrent with a pop: must be refused this cycle.
      in_valid = 1'b1; in_a = 64'd9; in_b = 64'd4; in_oper = 3'b001; in_tag = 4'd5;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("pop_occupancy", 64'(occupancy), 64'd3);
      chk("pop_in_ready", 64'(in_ready), 64'd1);
      chk("pop_out_tag", 64'(out_tag), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Streaming: one op per cycle across all opcodes.
      p0 = n_popped;
      c0 = cyc;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i == 8) send(all1, 64'd1, 3'b000, 4'(i));
         else if (i == 13) send(64'h1234, 64'h1234, 3'b101, 4'(i));
         else send({$urandom, $urandom}, {$urandom, $urandom}, 3'(i % 8), 4'(i));
      end
      chk("stream_cycles", 64'(cyc - c0), 64'd32);
      drain();
      chk("stream_results", 64'(n_popped - p0), 64'd32);

      // Reset with work in flight discards everything.
      out_ready = 1'b0;
      for (int unsigned i = 0; i < 4; i++)
         send({$urandom, $urandom}, {$urandom, $urandom}, 3'(i), 4'(i + 8));
      chk("pre_rst_occupancy", 64'(occupancy), 64'd3);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_occupancy", 64'(occupancy), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_alu_oper", 64'(alu_oper), 64'd7);
      out_ready = 1'b1;
      p0 = n_popped;
      send(64'd100, 64'd58, 3'b001, 4'd15);
      drain();
      chk("post_rst_results", 64'(n_popped - p0), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_64bit_issue_stage.md
Name: alu_64bit_issue_stage

Overview:
Issue/retire stage wrapped around the 64-bit combinational ALU.
- Accepts operations (a, b, Oper, tag) on a valid/ready input, buffers them in a DEPTH-entry FIFO, and presents the FIFO head to the ALU.
- Captures the ALU sum into a registered output slot with valid/ready backpressure.
- Sustains one operation per cycle; the ALU remains a separate combinational instance, connected through the alu_* ports.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- TAG_W, 4, width of the opaque tag carried from input to output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input operation valid.
- in_ready  out  1  stage can accept; equals !full.
- in_a  in  64  operand a.
- in_b  in  64  operand b.
- in_oper  in  3  ALU opcode (000 add, 001 a-b, 010 b-a, 011 or, 100 and, 101 xor, 110 xnor, 111 illegal).
- in_tag  in  TAG_W  opaque tag.
- alu_a  out  64  to ALU a.
- alu_b  out  64  to ALU b.
- alu_oper  out  3  to ALU Oper.
- alu_sum  in  64  from ALU sum (combinational return).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  64  registered result.
- out_tag  out  TAG_W  tag of result.
- out_zero  out  1  out_sum == 0.
- out_illegal  out  1  opcode was 111.
- occupancy  out  $clog2(DEPTH+1)  FIFO entry count.

Behaviour:
Clock and reset
- Single clock clk, rising edge. Reset is synchronous and active-low on rst_n.
- While rst_n=0 at an edge: FIFO pointers and occupancy to 0; out_valid=0; out_sum=0; out_tag=0; out_zero=0; out_illegal=0.
- Reset mid-operation discards all buffered and in-flight operations; nothing is replayed.

Push
- push = in_valid & in_ready.
- in_ready = (occupancy != DEPTH). A same-cycle pop does not raise in_ready when full: no fall-through.

ALU drive
- Head entry drives alu_a/alu_b/alu_oper combinationally from FIFO storage.
- When empty: alu_a=0, alu_b=0, alu_oper=3'b111 (ALU returns 0).

Output slot (single register)
- load = !empty & (!out_valid | out_ready).
- On load:
  - out_sum <= alu_sum
  - out_tag <= head tag
  - out_zero <= (alu_sum == 0)
  - out_illegal <= (head oper == 3'b111)
  - out_valid <= 1
  - FIFO pops head.
- Else if out_valid & out_ready: out_valid <= 0. Data registers hold their last value.
- While out_valid=1 & out_ready=0: all out_* are stable.

Latency and throughput
- Latency: operation accepted at edge E0 appears with out_valid=1 after edge E1 (2 cycles).
- Throughput: 1 op/cycle with out_ready held high.

FIFO and arithmetic rules
- Simultaneous push and pop: occupancy unchanged; pointers wrap modulo DEPTH.
- Results are in-order; tags are not interpreted.
- Arithmetic is the ALU's responsibility; the stage treats alu_sum as opaque 64 bits. Wrap-around (e.g. 0xFFFF_FFFF_FFFF_FFFF + 1 = 0) is expected and flagged out_zero=1.
- Illegal opcode 111 is not rejected: it flows through with sum 0, out_zero=1, out_illegal=1.
- No X on outputs after reset.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD=3'b000, OP_SUBAB=3'b001, OP_SUBBA=3'b010, OP_OR, OP_AND, OP_XOR, OP_XNOR, OP_ILLEGAL=3'b111.
  - struct alu_cmd_t {a[63:0], b[63:0], oper[2:0], tag}.
- One natural sub-module: alu_cmd_fifo, a parameterised synchronous FIFO storing alu_cmd_t, with push/pop/full/empty/count.
- Output-slot logic stays in the top.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then a=5, b=3, oper=001, tag=1 -> two edges later out_valid=1, out_sum=2, out_tag=1, out_zero=0.
- a=5, b=3, oper=010 -> out_sum=64'hFFFF_FFFF_FFFF_FFFE. Then a=64'hFFFF_FFFF_FFFF_FFFF, b=1, oper=000 -> out_sum=0, out_zero=1.
- out_ready=0 while pushing 5 ops (DEPTH=4):
  - After 5 accepted ops (1 in the output slot + 4 in the FIFO): in_ready=0, occupancy=4, out_* stable.
  - Raise out_ready -> tags emerge in order 0..4, one per cycle, no loss or duplication.
- Continuous push with out_ready=1 for 32 ops over all 8 opcodes -> one result per cycle, matching a scoreboard model. oper=111 gives out_sum=0, out_illegal=1.
- Full FIFO with simultaneous push attempt and pop -> push refused (in_ready=0), occupancy drops to 3 next cycle.
- Assert rst_n=0 for one edge with occupancy=3 and out_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, alu_oper=3'b111. A following op completes normally.
